riscv_decode_stage: RTL and testbench
=====================================

# riscv_decode_stage

Registered instruction-decode stage of the RV32I core. It sits between fetch and the execute-stage ALU. It accepts one fetched instruction per valid/ready handshake, reads the register file, and resolves operands through optional forwarding. It stalls on load-use hazards and presents a registered ID/EX payload (ALU opcode, two operands, control flags) to execute.

## Interface
- XLEN, 32, datapath width; only 32 is supported.
- clk_i  in  1  core clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- flush_i  in  1  kill the instruction held in the ID/EX register and the one offered on fetch this cycle.
- if_valid_i  in  1  fetch offers an instruction.
- if_ready_o  out  1  stage accepts the instruction this cycle.
- if_instr_i  in  32  instruction word.
- if_pc_i  in  32  PC of the instruction.
- rf_raddr_a_o / rf_raddr_b_o  out  5  rs1/rs2, combinational from if_instr_i.
- rf_rdata_a_i / rf_rdata_b_i  in  32  same-cycle register-file read data.
- fwd_valid_i  in  1  a writeback result is available this cycle.
- fwd_rd_i  in  5  destination register of that result.
- fwd_data_i  in  32  the result value.
- ex_valid_o  out  1  ID/EX payload is valid.
- ex_ready_i  in  1  execute consumes the payload.
- ex_alu_op_o  out  4  ALU opcode from the shared package.
- ex_operand_a_o / ex_operand_b_o  out  32  ALU operands.
- ex_store_data_o  out  32  forwarded rs2 value.
- ex_imm_o  out  32  decoded immediate.
- ex_pc_o  out  32  instruction PC.
- ex_funct3_o  out  3  instr[14:12].
- ex_rd_o  out  5  destination register.
- ex_rd_we_o  out  1  register write enable; forced to 0 when rd = x0.
- ex_is_load_o / ex_is_store_o / ex_is_branch_o / ex_is_jump_o / ex_illegal_o  out  1  instruction-class flags.

## Operation
- **OP:** a=rs1, b=rs2. alu_op comes from funct3, with funct7[5] selecting SUB/SRA.
- **OP-IMM:** a=rs1, b=imm_i. For SRLI/SRAI, funct7[5] selects SRA.
- **LUI:** alu_op=PASS_B, b=imm_u.
- **AUIPC:** a=pc, b=imm_u, ADD.
- **JAL/JALR:** a=pc, b=4, ADD, is_jump=1. imm carries imm_j/imm_i.
- **BRANCH:** a=rs1, b=rs2, SUB, is_branch=1, rd_we=0.
- **LOAD/STORE:** a=rs1, b=imm_i/imm_s, ADD. Store sets rd_we=0.
- **Any other opcode:** illegal=1, rd_we=0, alu_op=ADD, operands 0.
- **Operand source, per rs:** if rs = 0, value is 0. Otherwise, if forwarding matches, use fwd_data_i; else use rf_rdata.
- **Load-use hazard:** raised when ex_valid_o and ex_is_load_o are set, ex_rd_o≠0, and ex_rd_o equals a used rs of the incoming instruction.
- **State (implicit FSM):** EMPTY (ex_valid_o=0) or FULL.
  - Advance = !ex_valid_o || ex_ready_i.
  - On advance with an accepted instruction, load the payload and go FULL.
  - On advance with no accept (fetch invalid or hazard), insert a bubble: go EMPTY.
  - On no advance, hold the payload unchanged.
- **if_ready_o** = advance && !hazard && !flush_i.
- **flush_i:** has priority over everything. Next cycle ex_valid_o=0, and nothing is accepted in the flush cycle.

## Timing
- Latency: accepted in cycle N, so ex_valid_o and payload are visible in cycle N+1.
- Throughput: 1 instruction/cycle with no hazards and ex_ready_i=1.
- Load-use costs exactly 1 bubble cycle. The instruction stays offered and is accepted on the following cycle.
- Reset: ex_valid_o=0 and all ex_* payload outputs 0. if_ready_o is 0 while rst_i=1.
- Reset mid-stall discards the held payload.
- Simultaneous flush_i and ex_ready_i: the payload is consumed and the next state is EMPTY.
- Payload must not change while ex_valid_o && !ex_ready_i.

## Configuration
- **RISCV_DECODE_FWD_EN defined:** forwarding is active. A match is fwd_valid_i && fwd_rd_i==rs && rs≠0.
- **RISCV_DECODE_FWD_EN undefined:** the fwd_* inputs are ignored and the hazard is widened to stall on any match against:
  - the ID/EX register: ex_valid_o && ex_rd_we_o && ex_rd_o==rs;
  - the writeback result: fwd_valid_i && fwd_rd_i==rs.
- Port list is identical in both builds.

## Structure
- Shared package riscv_pkg holds:
  - ALU opcode constants: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001, PASS_A 1010, PASS_B 1011;
  - RV32I opcode constants;
  - an id_ex_t payload struct.
- One sub-module, riscv_imm_gen: a combinational instr → imm_i/s/b/u/j generator.

## Test plan
- ADDI x1,x0,5 (0x00500093) with ex_ready_i=1 → next cycle ex_alu_op_o=0000, a=0, b=5, rd=1, rd_we=1.
- SUB x3,x1,x2 (0x402081B3), rf a=10, b=3 → alu_op=0001, a=10, b=3. LUI x7,0x12345 (0x123453B7) → alu_op=1011, b=0x12345000.
- LW x5,0(x1) (0x0000A283) then ADD x6,x5,x5 (0x00528333) → if_ready_o=0 for one cycle, one bubble, ADD issued the cycle after.
- ex_ready_i=0 for 3 cycles with ex_valid_o=1 → payload stable and if_ready_o=0. Releasing it resumes with no loss or duplication.
- flush_i pulsed while FULL and fetch valid → ex_valid_o=0 next cycle, the offered instruction is not accepted.
- FWD_EN build: fwd_valid_i=1, fwd_rd_i=1, fwd_data_i=0xDEADBEEF, ADD x2,x1,x0 → operand_a=0xDEADBEEF. Non-FWD build, same stimulus → stall until fwd_valid_i drops.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: ALU opcodes, base opcodes and the ID/EX payload.
package riscv_pkg;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0001;
    localparam logic [3:0] ALU_AND    = 4'b0010;
    localparam logic [3:0] ALU_OR     = 4'b0011;
    localparam logic [3:0] ALU_XOR    = 4'b0100;
    localparam logic [3:0] ALU_SLL    = 4'b0101;
    localparam logic [3:0] ALU_SRL    = 4'b0110;
    localparam logic [3:0] ALU_SRA    = 4'b0111;
    localparam logic [3:0] ALU_SLT    = 4'b1000;
    localparam logic [3:0] ALU_SLTU   = 4'b1001;
    localparam logic [3:0] ALU_PASS_A = 4'b1010;
    localparam logic [3:0] ALU_PASS_B = 4'b1011;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [3:0]  alu_op;
        logic [31:0] operand_a;
        logic [31:0] operand_b;
        logic [31:0] store_data;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic        rd_we;
        logic        is_load;
        logic        is_store;
        logic        is_branch;
        logic        is_jump;
        logic        illegal;
    } id_ex_t;

endpackage

// File: rtl/riscv_imm_gen.sv
// Combinational RV32I immediate generator; the opcode bits are not needed here.
module riscv_imm_gen (
    input  logic [31:7] instr,
    output logic [31:0] imm_i,
    output logic [31:0] imm_s,
    output logic [31:0] imm_b,
    output logic [31:0] imm_u,
    output logic [31:0] imm_j
);

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

endmodule

// File: rtl/riscv_decode_stage.sv
// RV32I decode stage with registered ID/EX payload and load-use stalling.
// Define RISCV_DECODE_FWD_EN to forward writeback results; otherwise such dependencies stall.
module riscv_decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            if_valid_i,
    output logic            if_ready_o,
    input  logic [31:0]     if_instr_i,
    input  logic [XLEN-1:0] if_pc_i,
    output logic [4:0]      rf_raddr_a_o,
    output logic [4:0]      rf_raddr_b_o,
    input  logic [XLEN-1:0] rf_rdata_a_i,
    input  logic [XLEN-1:0] rf_rdata_b_i,
    input  logic            fwd_valid_i,
    input  logic [4:0]      fwd_rd_i,
    input  logic [XLEN-1:0] fwd_data_i,
    output logic            ex_valid_o,
    input  logic            ex_ready_i,
    output logic [3:0]      ex_alu_op_o,
    output logic [XLEN-1:0] ex_operand_a_o,
    output logic [XLEN-1:0] ex_operand_b_o,
    output logic [XLEN-1:0] ex_store_data_o,
    output logic [XLEN-1:0] ex_imm_o,
    output logic [XLEN-1:0] ex_pc_o,
    output logic [2:0]      ex_funct3_o,
    output logic [4:0]      ex_rd_o,
    output logic            ex_rd_we_o,
    output logic            ex_is_load_o,
    output logic            ex_is_store_o,
    output logic            ex_is_branch_o,
    output logic            ex_is_jump_o,
    output logic            ex_illegal_o
);

    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

    state_t      state_p1;
    id_ex_t      ex_p1;
    id_ex_t      dec;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic        alt;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val;
    logic        use_rs1, use_rs2, writes_rd;
    logic        vld_p1, load_use, hazard, advance, accept;

    function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic f7b5,
                                                   input logic is_reg);
        case (f3)
            3'b000:  return (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    assign opcode = if_instr_i[6:0];
    assign rd     = if_instr_i[11:7];
    assign funct3 = if_instr_i[14:12];
    assign rs1    = if_instr_i[19:15];
    assign rs2    = if_instr_i[24:20];
    assign alt    = if_instr_i[30];

    assign rf_raddr_a_o = rs1;
    assign rf_raddr_b_o = rs2;

    riscv_imm_gen u_imm_gen (
        .instr (if_instr_i[31:7]),
        .imm_i (imm_i),
        .imm_s (imm_s),
        .imm_b (imm_b),
        .imm_u (imm_u),
        .imm_j (imm_j)
    );

    always_comb begin
        rs1_val = rf_rdata_a_i;
        rs2_val = rf_rdata_b_i;
`ifdef RISCV_DECODE_FWD_EN
        if (fwd_valid_i && fwd_rd_i == rs1) rs1_val = fwd_data_i;
        if (fwd_valid_i && fwd_rd_i == rs2) rs2_val = fwd_data_i;
`endif
        if (rs1 == 5'd0) rs1_val = '0;
        if (rs2 == 5'd0) rs2_val = '0;
    end

`ifndef RISCV_DECODE_FWD_EN
    logic unused_fwd_data;
    assign unused_fwd_data = ^fwd_data_i;
`endif

    // Instruction decode into the next ID/EX payload
    always_comb begin
        dec            = '0;
        dec.alu_op     = ALU_ADD;
        dec.pc         = if_pc_i;
        dec.funct3     = funct3;
        dec.rd         = rd;
        dec.store_data = rs2_val;
        use_rs1        = 1'b0;
        use_rs2        = 1'b0;
        writes_rd      = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec.alu_op    = alu_from_funct3(funct3, alt, 1'b1);
                dec.operand_a = rs1_val;
                dec.operand_b = rs2_val;
                use_rs1 = 1'b1; use_rs2 = 1'b1; writes_rd = 1'b1;
            end
            OPC_OP_IMM: begin
                dec.alu_op    = alu_from_funct3(funct3, alt, 1'b0);
                dec.operand_a = rs1_val;
                dec.operand_b = imm_i;
                dec.imm       = imm_i;
                use_rs1 = 1'b1; writes_rd = 1'b1;
            end
            OPC_LUI: begin
                dec.alu_op    = ALU_PASS_B;
                dec.operand_b = imm_u;
                dec.imm       = imm_u;
                writes_rd     = 1'b1;
            end
            OPC_AUIPC: begin
                dec.operand_a = if_pc_i;
                dec.operand_b = imm_u;
                dec.imm       = imm_u;
                writes_rd     = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                dec.operand_a = if_pc_i;
                dec.operand_b = 32'd4;
                dec.imm       = (opcode == OPC_JAL) ? imm_j : imm_i;
                dec.is_jump   = 1'b1;
                use_rs1       = (opcode == OPC_JALR);
                writes_rd     = 1'b1;
            end
            OPC_BRANCH: begin
                dec.alu_op    = ALU_SUB;
                dec.operand_a = rs1_val;
                dec.operand_b = rs2_val;
                dec.imm       = imm_b;
                dec.is_branch = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OPC_LOAD: begin
                dec.operand_a = rs1_val;
                dec.operand_b = imm_i;
                dec.imm       = imm_i;
                dec.is_load   = 1'b1;
                use_rs1 = 1'b1; writes_rd = 1'b1;
            end
            OPC_STORE: begin
                dec.operand_a = rs1_val;
                dec.operand_b = imm_s;
                dec.imm       = imm_s;
                dec.is_store  = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
        dec.rd_we = writes_rd && (rd != 5'd0);
    end

    assign vld_p1 = (state_p1 == ST_FULL);

    assign load_use = vld_p1 && ex_p1.is_load && (ex_p1.rd != 5'd0) &&
                      ((use_rs1 && ex_p1.rd == rs1) || (use_rs2 && ex_p1.rd == rs2));

`ifdef RISCV_DECODE_FWD_EN
    assign hazard = load_use;
`else
    // Without forwarding, any in-flight producer of a used source must drain first
    logic dep_rs1, dep_rs2;
    assign dep_rs1 = use_rs1 && (rs1 != 5'd0) &&
                     ((vld_p1 && ex_p1.rd_we && ex_p1.rd == rs1) || (fwd_valid_i && fwd_rd_i == rs1));
    assign dep_rs2 = use_rs2 && (rs2 != 5'd0) &&
                     ((vld_p1 && ex_p1.rd_we && ex_p1.rd == rs2) || (fwd_valid_i && fwd_rd_i == rs2));
    assign hazard  = load_use || dep_rs1 || dep_rs2;
`endif

    assign advance    = !vld_p1 || ex_ready_i;
    assign if_ready_o = advance && !hazard && !flush_i && !rst_i;
    assign accept     = if_valid_i && if_ready_o;

    // ID/EX register boundary
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_p1 <= ST_EMPTY;
            ex_p1    <= '0;
        end else if (flush_i) begin
            state_p1 <= ST_EMPTY;
        end else if (advance) begin
            if (accept) begin
                ex_p1    <= dec;
                state_p1 <= ST_FULL;
            end else begin
                state_p1 <= ST_EMPTY;
            end
        end
    end

    assign ex_valid_o      = vld_p1;
    assign ex_alu_op_o     = ex_p1.alu_op;
    assign ex_operand_a_o  = ex_p1.operand_a;
    assign ex_operand_b_o  = ex_p1.operand_b;
    assign ex_store_data_o = ex_p1.store_data;
    assign ex_imm_o        = ex_p1.imm;
    assign ex_pc_o         = ex_p1.pc;
    assign ex_funct3_o     = ex_p1.funct3;
    assign ex_rd_o         = ex_p1.rd;
    assign ex_rd_we_o      = ex_p1.rd_we;
    assign ex_is_load_o    = ex_p1.is_load;
    assign ex_is_store_o   = ex_p1.is_store;
    assign ex_is_branch_o  = ex_p1.is_branch;
    assign ex_is_jump_o    = ex_p1.is_jump;
    assign ex_illegal_o    = ex_p1.illegal;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Scoreboard bench for riscv_decode_stage: directed instructions with hand-derived payloads.
`timescale 1ns/1ps
module tb_riscv_decode_stage;

    logic        clk = 1'b0;
    logic        rst, flush, if_valid, if_ready, ex_valid, ex_ready;
    logic [31:0] if_instr, if_pc, rf_a, rf_b, fwd_data;
    logic [4:0]  raddr_a, raddr_b, fwd_rd;
    logic        fwd_valid;
    logic [3:0]  alu_op;
    logic [31:0] op_a, op_b, store_data, imm, pc_out;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        rd_we, is_load, is_store, is_branch, is_jump, illegal;

    always #5 clk = ~clk;

    riscv_decode_stage dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .if_valid_i(if_valid), .if_ready_o(if_ready), .if_instr_i(if_instr), .if_pc_i(if_pc),
        .rf_raddr_a_o(raddr_a), .rf_raddr_b_o(raddr_b), .rf_rdata_a_i(rf_a), .rf_rdata_b_i(rf_b),
        .fwd_valid_i(fwd_valid), .fwd_rd_i(fwd_rd), .fwd_data_i(fwd_data),
        .ex_valid_o(ex_valid), .ex_ready_i(ex_ready), .ex_alu_op_o(alu_op),
        .ex_operand_a_o(op_a), .ex_operand_b_o(op_b), .ex_store_data_o(store_data),
        .ex_imm_o(imm), .ex_pc_o(pc_out), .ex_funct3_o(funct3), .ex_rd_o(rd), .ex_rd_we_o(rd_we),
        .ex_is_load_o(is_load), .ex_is_store_o(is_store), .ex_is_branch_o(is_branch),
        .ex_is_jump_o(is_jump), .ex_illegal_o(illegal)
    );

    // flags = {rd_we, is_load, is_store, is_branch, is_jump, illegal}
    typedef struct packed {
        logic [3:0]  alu;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [5:0]  flags;
    } pl_t;

    typedef struct {
        pl_t         pl;
        logic        chk_sd;
        logic [31:0] sd;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    pl_t  act;
    exp_t got;

    function automatic pl_t mk(input logic [3:0] alu, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] im, input logic [31:0] pc, input logic [4:0] r,
                               input logic [5:0] flags);
        pl_t p;
        p.alu = alu; p.a = a; p.b = b; p.imm = im; p.pc = pc; p.rd = r; p.flags = flags;
        return p;
    endfunction

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: every consumed payload must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && ex_valid && ex_ready) begin
            act = {alu_op, op_a, op_b, imm, pc_out, rd,
                   {rd_we, is_load, is_store, is_branch, is_jump, illegal}};
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: got payload %h expected none", act);
            end else begin
                got = sb.pop_front();
                if (act !== got.pl) begin
                    n_bad++;
                    $display("FAIL sb_payload: got %h expected %h", act, got.pl);
                end
                if (got.chk_sd) begin
                    n_cmp++;
                    if (store_data !== got.sd) begin
                        n_bad++;
                        $display("FAIL sb_store_data: got %h expected %h", store_data, got.sd);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] ra, input logic [31:0] rb);
        if_valid = 1'b1; if_instr = instr; if_pc = pc; rf_a = ra; rf_b = rb;
    endtask

    task automatic push(input pl_t p, input logic chk_sd, input logic [31:0] sd);
        exp_t e;
        e.pl = p; e.chk_sd = chk_sd; e.sd = sd;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] ra,
                         input logic [31:0] rb, input pl_t p, input logic chk_sd,
                         input logic [31:0] sd);
        bit done;
        done = 1'b0;
        drive(instr, pc, ra, rb);
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (if_ready) begin
                push(p, chk_sd, sd);
                done = 1'b1;
            end
            step();
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: instr %h not accepted in 20 cycles", instr);
        end
        if_valid = 1'b0;
    endtask

    task automatic drain();
        if_valid = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
        fwd_valid = 1'b0; fwd_rd = 5'd0; fwd_data = 32'h0;
        drive(32'h00500093, 32'h0, 32'h0, 32'h0);
        step(); step();
        @(negedge clk);
        check("rst_ex_valid", 64'(ex_valid), 64'd0);
        check("rst_if_ready", 64'(if_ready), 64'd0);
        check("rst_payload", 64'(|{alu_op, op_a, op_b, store_data, imm, pc_out, funct3, rd,
                                   rd_we, is_load, is_store, is_branch, is_jump, illegal}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; if_valid = 1'b0;
        step();

        // Back-to-back stream of instruction classes
        issue(32'h00500093, 32'h1000, 32'h11111111, 32'h22222222,
              mk(4'b0000, 32'd0, 32'd5, 32'd5, 32'h1000, 5'd1, 6'b100000), 1'b0, 32'h0);
        issue(32'h402081B3, 32'h1004, 32'd10, 32'd3,
              mk(4'b0001, 32'd10, 32'd3, 32'd0, 32'h1004, 5'd3, 6'b100000), 1'b0, 32'h0);
        issue(32'h123453B7, 32'h1008, 32'h0, 32'h0,
              mk(4'b1011, 32'd0, 32'h12345000, 32'h12345000, 32'h1008, 5'd7, 6'b100000), 1'b0, 32'h0);
        issue(32'h00001217, 32'h100C, 32'h0, 32'h0,
              mk(4'b0000, 32'h100C, 32'h1000, 32'h1000, 32'h100C, 5'd4, 6'b100000), 1'b0, 32'h0);
        issue(32'h008000EF, 32'h1010, 32'h0, 32'h0,
              mk(4'b0000, 32'h1010, 32'd4, 32'd8, 32'h1010, 5'd1, 6'b100010), 1'b0, 32'h0);
        issue(32'h00208863, 32'h1014, 32'd7, 32'd7,
              mk(4'b0001, 32'd7, 32'd7, 32'd16, 32'h1014, 5'd16, 6'b000100), 1'b0, 32'h0);
        issue(32'h0020A223, 32'h1018, 32'h1000, 32'hCAFE,
              mk(4'b0000, 32'h1000, 32'd4, 32'd4, 32'h1018, 5'd4, 6'b001000), 1'b1, 32'hCAFE);
        issue(32'h40335293, 32'h101C, 32'h80000000, 32'h0,
              mk(4'b0111, 32'h80000000, 32'h403, 32'h403, 32'h101C, 5'd5, 6'b100000), 1'b0, 32'h0);
        issue(32'hFFFFFFFF, 32'h1020, 32'h1234, 32'h5678,
              mk(4'b0000, 32'd0, 32'd0, 32'd0, 32'h1020, 5'd31, 6'b000001), 1'b0, 32'h0);
        drain();

        // Load-use: exactly one bubble, then the dependent ADD issues
        drive(32'h0000A283, 32'h4000, 32'h100, 32'h0);
        @(negedge clk);
        check("lu_first_rdy", 64'(if_ready), 64'd1);
        push(mk(4'b0000, 32'h100, 32'd0, 32'd0, 32'h4000, 5'd5, 6'b110000), 1'b0, 32'h0);
        step();
        drive(32'h00528333, 32'h4004, 32'h55, 32'h55);
        @(negedge clk);
        check("lu_stall", 64'(if_ready), 64'd0);
        step();
        @(negedge clk);
        check("lu_bubble", 64'(ex_valid), 64'd0);
        check("lu_retry", 64'(if_ready), 64'd1);
        push(mk(4'b0000, 32'h55, 32'h55, 32'd0, 32'h4004, 5'd6, 6'b100000), 1'b0, 32'h0);
        step();
        if_valid = 1'b0;
        @(negedge clk);
        check("lu_issue", 64'({ex_valid, rd}), 64'({1'b1, 5'd6}));
        drain();

        // Backpressure: payload frozen for 3 cycles, then no loss or duplication
        issue(32'h00500093, 32'h2000, 32'h0, 32'h0,
              mk(4'b0000, 32'd0, 32'd5, 32'd5, 32'h2000, 5'd1, 6'b100000), 1'b0, 32'h0);
        ex_ready = 1'b0;
        drive(32'h00700113, 32'h2004, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_valid", 64'(ex_valid), 64'd1);
            check("stall_rdy", 64'(if_ready), 64'd0);
            check("stall_payload", {27'd0, op_b[4:0], pc_out}, {27'd0, 5'd5, 32'h2000});
            step();
        end
        ex_ready = 1'b1;
        issue(32'h00700113, 32'h2004, 32'h0, 32'h0,
              mk(4'b0000, 32'd0, 32'd7, 32'd7, 32'h2004, 5'd2, 6'b100000), 1'b0, 32'h0);
        drain();

        // Flush while FULL and stalled: held entry killed, offered one refused
        issue(32'h00500093, 32'h3000, 32'h0, 32'h0,
              mk(4'b0000, 32'd0, 32'd5, 32'd5, 32'h3000, 5'd1, 6'b100000), 1'b0, 32'h0);
        ex_ready = 1'b0;
        drive(32'h00700113, 32'h3004, 32'h0, 32'h0);
        flush = 1'b1;
        @(negedge clk);
        check("flush_rdy", 64'(if_ready), 64'd0);
        step();
        flush = 1'b0; if_valid = 1'b0;
        void'(sb.pop_back());
        @(negedge clk);
        check("flush_kill", 64'(ex_valid), 64'd0);
        ex_ready = 1'b1;
        step();

        // Flush together with ex_ready: payload consumed, then EMPTY
        issue(32'h00500193, 32'h3008, 32'h0, 32'h0,
              mk(4'b0000, 32'd0, 32'd5, 32'd5, 32'h3008, 5'd3, 6'b100000), 1'b0, 32'h0);
        drive(32'h00700113, 32'h300C, 32'h0, 32'h0);
        flush = 1'b1;
        step();
        flush = 1'b0; if_valid = 1'b0;
        @(negedge clk);
        check("flush_consume", 64'(ex_valid), 64'd0);
        drain();

        // Writeback result targeting rs1
        fwd_valid = 1'b1; fwd_rd = 5'd1; fwd_data = 32'hDEADBEEF;
`ifdef RISCV_DECODE_FWD_EN
        issue(32'h00008133, 32'h5000, 32'd5, 32'd9,
              mk(4'b0000, 32'hDEADBEEF, 32'd0, 32'd0, 32'h5000, 5'd2, 6'b100000), 1'b0, 32'h0);
        fwd_valid = 1'b0;
`else
        drive(32'h00008133, 32'h5000, 32'd5, 32'd9);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("nofwd_stall", 64'(if_ready), 64'd0);
            step();
        end
        fwd_valid = 1'b0;
        issue(32'h00008133, 32'h5000, 32'd5, 32'd9,
              mk(4'b0000, 32'd5, 32'd0, 32'd0, 32'h5000, 5'd2, 6'b100000), 1'b0, 32'h0);
`endif
        drain();

        // Reset while stalled discards the held payload
        issue(32'h00500093, 32'h6000, 32'h0, 32'h0,
              mk(4'b0000, 32'd0, 32'd5, 32'd5, 32'h6000, 5'd1, 6'b100000), 1'b0, 32'h0);
        ex_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        void'(sb.pop_back());
        @(negedge clk);
        check("rst_midstall_valid", 64'(ex_valid), 64'd0);
        check("rst_midstall_payload", {op_b, pc_out}, 64'd0);
        ex_ready = 1'b1;
        drain();

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
